md_sched: RTL

- Sequencing and hazard controller for the multiply/divide unit in the E stage of the P7 pipeline.
- Accepts mult/multu/div/divu starts from the instruction in E and counts the fixed operation latency.
- Tells the HI/LO unit when to commit its result.
- While an operation is pending, stalls the F/D registers and clears the D/E pipeline register whenever the instruction in D touches HI/LO.
- Interrupt and eret requests override start and stall.

---
 rtl/md_sched.sv | 51 +++++
 1 files changed

// File: rtl/md_sched.sv
// Multiply/divide sequencer: counts fixed op latency, pulses the HI/LO commit
// and stalls D-stage HI/LO users while an op is pending.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op_E,
    input  logic       md_D,
    input  logic       IntReq,
    input  logic       eret,
    output logic       busy,
    output logic [1:0] op_cur,
    output logic       hilo_we,
    output logic       stall_FD,
    output logic       E_clr
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [3:0] cnt;
    logic       flush;
    logic       start_eff;
    logic       stall;

    assign flush     = IntReq | eret;
    assign busy      = (cnt != 4'd0);
    assign hilo_we   = (cnt == 4'd1);
    assign start_eff = start & ~busy & ~flush;

    // A flush drops a fresh start but never cancels an op already counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 4'd0;
            op_cur <= 2'b00;
        end else if (start_eff) begin
            cnt    <= op_E[1] ? DIV_N : MULT_N;
            op_cur <= op_E;
        end else if (busy) begin
            cnt    <= cnt - 4'd1;
        end
    end

    assign stall    = md_D & (start | busy) & ~flush;
    assign stall_FD = stall;
    assign E_clr    = stall;

endmodule
